// File: rtl/dot_product_engine.sv
// Dot-product engine: two Para_Deg-lane operand buffers feeding a 3-stage MAC pipeline
// (buffer read -> lane products -> lane sum + accumulate) under a start/busy/done handshake.
module dot_product_engine #(
    parameter int Addr_Width     = 4,
    parameter int Ram_Depth      = 1 << Addr_Width,
    parameter int Para_Deg       = 2,
    parameter int Data_Width_In  = 8,
    parameter int Data_Width_Out = 24
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              load_en,
    input  logic [Addr_Width-1:0]             load_addr,
    input  logic [Para_Deg*Data_Width_In-1:0] load_a,
    input  logic [Para_Deg*Data_Width_In-1:0] load_b,
    input  logic                              start,
    input  logic                              accumulate,
    input  logic [Addr_Width:0]               vec_len,
    output logic                              busy,
    output logic                              done,
    output logic [Data_Width_Out-1:0]         result,
    output logic [1:0]                        state
);

    // Handshake: start/accumulate/vec_len are sampled only while IDLE; busy stays high from the
    // cycle after an accepted start through the single-cycle done pulse, and result is final
    // whenever done is high and is held until the next accepted start.

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int WORD_W = Para_Deg * Data_Width_In;
    localparam int PROD_W = 2 * Data_Width_In;
    localparam logic [Addr_Width:0] DEPTH_L = (Addr_Width + 1)'(Ram_Depth);

    logic [1:0]                 state_q;
    logic [Addr_Width:0]        len_q;
    logic [Addr_Width:0]        cnt_q;
    logic                       drain_q;

    logic [WORD_W-1:0]          mem_a [Ram_Depth];
    logic [WORD_W-1:0]          mem_b [Ram_Depth];
    logic [WORD_W-1:0]          rd_a_q;
    logic [WORD_W-1:0]          rd_b_q;
    logic                       s1_vld_q;
    logic                       s2_vld_q;

    logic signed [PROD_W-1:0]   op_a [Para_Deg];
    logic signed [PROD_W-1:0]   op_b [Para_Deg];
    logic signed [PROD_W-1:0]   prod_q [Para_Deg];
    logic [Data_Width_Out-1:0]  lane_sum;
    logic [Data_Width_Out-1:0]  acc_q;

    logic                       start_ok;
    logic                       last_issue;
    logic [Addr_Width:0]        len_clamped;

    assign start_ok    = start && (state_q == IDLE);
    assign len_clamped = (vec_len > DEPTH_L) ? DEPTH_L : vec_len;
    assign last_issue  = (cnt_q == (len_q - 1'b1));

    // Loads are gated by IDLE so a running job always sees a stable buffer.
    always_ff @(posedge clk) begin
        if (load_en && (state_q == IDLE)) begin
            mem_a[load_addr] <= load_a;
            mem_b[load_addr] <= load_b;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RUN) begin
            rd_a_q <= mem_a[cnt_q[Addr_Width-1:0]];
            rd_b_q <= mem_b[cnt_q[Addr_Width-1:0]];
        end
    end

    always_comb begin
        for (int i = 0; i < Para_Deg; i++) begin
            op_a[i] = {{Data_Width_In{rd_a_q[i*Data_Width_In + Data_Width_In - 1]}},
                       rd_a_q[i*Data_Width_In +: Data_Width_In]};
            op_b[i] = {{Data_Width_In{rd_b_q[i*Data_Width_In + Data_Width_In - 1]}},
                       rd_b_q[i*Data_Width_In +: Data_Width_In]};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < Para_Deg; i++) begin
            prod_q[i] <= op_a[i] * op_b[i];
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < Para_Deg; i++) begin
            lane_sum = lane_sum + {{(Data_Width_Out - PROD_W){prod_q[i][PROD_W-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= (state_q == RUN);
            s2_vld_q <= s1_vld_q;
        end
    end

    // A start without accumulate seeds zero; with accumulate the held result is the seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (start_ok && !accumulate) begin
            acc_q <= '0;
        end else if (s2_vld_q) begin
            acc_q <= acc_q + lane_sum;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        len_q   <= len_clamped;
                        cnt_q   <= '0;
                        drain_q <= 1'b0;
                        state_q <= (len_clamped == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt_q   <= cnt_q + 1'b1;
                    drain_q <= 1'b0;
                    if (last_issue) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = acc_q;
    assign state  = state_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed vector table, busy protection,
// reset abort, and randomized jobs against an arithmetic reference model.
module tb_dot_product_engine;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int PD    = 2;
    localparam int DWI   = 8;
    localparam int DWO   = 24;
    localparam int W     = PD * DWI;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           load_en = 1'b0;
    logic [AW-1:0]  load_addr = '0;
    logic [W-1:0]   load_a = '0;
    logic [W-1:0]   load_b = '0;
    logic           start = 1'b0;
    logic           accumulate = 1'b0;
    logic [AW:0]    vec_len = '0;
    logic           busy;
    logic           done;
    logic [DWO-1:0] result;
    logic [1:0]     state;

    dot_product_engine #(
        .Addr_Width(AW), .Ram_Depth(DEPTH), .Para_Deg(PD),
        .Data_Width_In(DWI), .Data_Width_Out(DWO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_a(load_a), .load_b(load_b), .start(start), .accumulate(accumulate),
        .vec_len(vec_len), .busy(busy), .done(done), .result(result), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference buffer contents and the result the engine should be holding.
    int             ma [DEPTH][PD];
    int             mb [DEPTH][PD];
    logic [DWO-1:0] model_result = '0;
    logic [DWO-1:0] exp_q [$];

    typedef struct {
        bit       load_big;
        int       len;
        bit       acc;
        int       res;
        int       cyc;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_word(input int addr, input int a0, input int a1, input int b0, input int b1);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_a    = {8'(a1), 8'(a0)};
        load_b    = {8'(b1), 8'(b0)};
        @(negedge clk);
        load_en = 1'b0;
        ma[addr][0] = a0; ma[addr][1] = a1;
        mb[addr][0] = b0; mb[addr][1] = b1;
    endtask

    function automatic int rnd_elem();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Drives one job and checks result, done latency, pulse width and busy.
    // With disturb set, start and load_en are hammered during RUN; both must be ignored.
    task automatic run_job(input int len, input bit acc, input bit disturb,
                           output logic [DWO-1:0] res, output int cyc);
        int lc;
        longint dot;
        bit found;
        logic [DWO-1:0] exp;
        lc  = (len > DEPTH) ? DEPTH : len;
        dot = 0;
        for (int w = 0; w < lc; w++)
            for (int l = 0; l < PD; l++)
                dot += longint'(ma[w][l]) * longint'(mb[w][l]);
        model_result = (acc ? model_result : '0) + DWO'(dot);
        exp_q.push_back(model_result);

        @(negedge clk);
        start      = 1'b1;
        vec_len    = (AW+1)'(len);
        accumulate = acc;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        cyc   = 0;
        res   = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            if (disturb && c == 2) check("state_run", state, 1);
            if (done) begin
                cyc   = c;
                found = 1'b1;
                break;
            end
            if (disturb && c >= 2 && c <= 5) begin
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = AW'(c);
                load_a    = W'($urandom);
                load_b    = W'($urandom);
            end else begin
                start   = 1'b0;
                load_en = 1'b0;
            end
        end
        start   = 1'b0;
        load_en = 1'b0;
        exp = exp_q.pop_front();
        if (!found) begin
            check("done_timeout", 0, 1);
        end else begin
            res = result;
            check("result", result, exp);
            check("done_cycle", cyc, (lc == 0) ? 1 : lc + 3);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("idle_after_done", state, 0);
        end
    endtask

    vec_t vecs [10];
    logic [DWO-1:0] r;
    int cyc;
    int n_done;

    initial begin
        vecs[0] = '{0, 2,  0, 23,      5};
        vecs[1] = '{0, 2,  1, 46,      5};
        vecs[2] = '{0, 0,  0, 0,       1};
        vecs[3] = '{0, 1,  1, 22,      4};
        vecs[4] = '{0, 1,  1, 44,      4};
        vecs[5] = '{0, 0,  1, 44,      1};
        vecs[6] = '{0, 2,  0, 23,      5};
        vecs[7] = '{1, 16, 0, 524288,  19};
        vecs[8] = '{0, 31, 0, 524288,  19};
        vecs[9] = '{0, 16, 1, 1048576, 19};

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_state", state, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);

        // Directed table
        load_word(0, 3, 2, 4, 5);
        load_word(1, -1, 7, 6, 1);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].load_big)
                for (int w = 0; w < DEPTH; w++) load_word(w, -128, -128, -128, -128);
            run_job(vecs[i].len, vecs[i].acc, 1'b0, r, cyc);
            check($sformatf("table%0d_result", i), r, vecs[i].res);
            check($sformatf("table%0d_cycle", i), cyc, vecs[i].cyc);
        end

        // Busy protection: disturbed job, then rerun to confirm the buffer was untouched
        for (int w = 0; w < DEPTH; w++) load_word(w, rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
        run_job(16, 1'b0, 1'b1, r, cyc);
        run_job(16, 1'b0, 1'b0, r, cyc);

        // Randomized jobs
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0)
                for (int k = 0; k < 3; k++)
                    load_word(int'($urandom_range(0, DEPTH-1)), rnd_elem(), rnd_elem(), rnd_elem(), rnd_elem());
            run_job(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, r, cyc);
        end

        // Reset during DRAIN aborts the job
        @(negedge clk);
        start = 1'b1; vec_len = 5'd4; accumulate = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (state == 2'd2) break;
        end
        check("reached_drain", state, 2);
        reset_n = 1'b0;
        #1;
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_result = '0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        run_job(4, 1'b1, 1'b0, r, cyc);
        run_job(16, 1'b1, 1'b0, r, cyc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
